// File: rtl/dec_onehot_pkg.sv
// -----------------------------------------------------------------------------
// dec_onehot_pkg
// Shared defaults for the one-hot to binary decoder family.
//   W_BIN     : binary index width
//   W_OH      : one-hot word width (2**W_BIN - 1)
//   CNT_W     : width of the saturating multi-hot error counter
//   NONE_CODE : index reported for the all-zero word
//   onehot_popcnt_gt1() : true when a word (zero-extended to 32 bits) has two
//                         or more bits set
// -----------------------------------------------------------------------------
package dec_onehot_pkg;

  localparam int W_BIN = 4;
  localparam int W_OH  = 15;
  localparam int CNT_W = 8;

  localparam logic [W_BIN-1:0] NONE_CODE = {W_BIN{1'b1}};

  // Clearing the lowest set bit leaves something behind only if more than one
  // bit was set.
  function automatic logic onehot_popcnt_gt1(input logic [31:0] v);
    return ((v & (v - 32'd1)) != 32'd0);
  endfunction

endpackage : dec_onehot_pkg

// File: rtl/oh_prio_enc.sv
// -----------------------------------------------------------------------------
// oh_prio_enc
// Combinational lowest-bit priority encoder for one-hot words.
// Ports:
//   in    [W_OH-1:0]  : word to encode
//   idx   [W_BIN-1:0] : index of the lowest set bit (all ones when in is zero)
//   zero              : no bit set
//   multi             : two or more bits set
// -----------------------------------------------------------------------------
module oh_prio_enc #(
  parameter int W_BIN = dec_onehot_pkg::W_BIN,
  parameter int W_OH  = dec_onehot_pkg::W_OH
) (
  input  logic [W_OH-1:0]  in,
  output logic [W_BIN-1:0] idx,
  output logic             zero,
  output logic             multi
);
  import dec_onehot_pkg::*;

  logic [W_BIN-1:0] idx_s;

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_s = {W_BIN{1'b1}};
    for (int i = W_OH - 1; i >= 0; i--) begin
      if (in[i]) begin
        idx_s = W_BIN'(i);
      end else begin
        idx_s = idx_s;
      end
    end
  end

  assign idx   = idx_s;
  assign zero  = (in == {W_OH{1'b0}});
  assign multi = onehot_popcnt_gt1(32'(in));

endmodule : oh_prio_enc

// File: rtl/dec_onehot2bin.sv
// -----------------------------------------------------------------------------
// dec_onehot2bin
// One-hot to binary decoder with a single registered output stage and
// valid/ready handshakes on both sides. The all-zero word decodes to the
// top index; multi-hot words decode to their lowest set bit, are flagged on
// out_err and counted in a saturating counter.
// Ports:
//   clk, rst (sync, active-low)
//   in_valid / in_ready / in [W_OH-1:0]      : input handshake and word
//   out_valid / out_ready / out [W_BIN-1:0]  : registered result handshake
//   out_err                                  : result came from a multi-hot word
//   err_cnt [CNT_W-1:0], err_clr             : multi-hot counter and its clear
// -----------------------------------------------------------------------------
module dec_onehot2bin #(
  parameter int W_BIN = dec_onehot_pkg::W_BIN,
  parameter int W_OH  = dec_onehot_pkg::W_OH,
  parameter int CNT_W = dec_onehot_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W_OH-1:0]  in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_BIN-1:0] out,
  output logic             out_err,
  output logic [CNT_W-1:0] err_cnt,
  input  logic             err_clr
);
  import dec_onehot_pkg::*;

  localparam logic [W_BIN-1:0] NONE_IDX = {W_BIN{1'b1}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [W_BIN-1:0] enc_idx_s;
  logic             enc_zero_s;
  logic             enc_multi_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             err_hit_s;

  logic             out_valid_r;
  logic [W_BIN-1:0] out_r;
  logic             out_err_r;
  logic [CNT_W-1:0] err_cnt_r;

  oh_prio_enc #(
    .W_BIN (W_BIN),
    .W_OH  (W_OH)
  ) u_enc (
    .in    (in),
    .idx   (enc_idx_s),
    .zero  (enc_zero_s),
    .multi (enc_multi_s)
  );

  // The stage can take a new word whenever it is empty or being drained now.
  assign in_ready_s = !out_valid_r || out_ready;
  assign accept_s   = in_valid && in_ready_s;
  assign err_hit_s  = accept_s && enc_multi_s;

  // Output register stage: load on accept, drop valid on a plain drain, else hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      out_r       <= {W_BIN{1'b0}};
      out_err_r   <= 1'b0;
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_r       <= enc_zero_s ? NONE_IDX : enc_idx_s;
      out_err_r   <= enc_multi_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  // Saturating multi-hot counter; a clear that coincides with a hit restarts at one.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt_r <= {CNT_W{1'b0}};
    end else if (err_clr) begin
      err_cnt_r <= err_hit_s ? CNT_ONE : {CNT_W{1'b0}};
    end else if (err_hit_s && (err_cnt_r != CNT_MAX)) begin
      err_cnt_r <= err_cnt_r + CNT_ONE;
    end else begin
      err_cnt_r <= err_cnt_r;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out       = out_r;
  assign out_err   = out_err_r;
  assign err_cnt   = err_cnt_r;

endmodule : dec_onehot2bin

// File: tb/tb_dec_onehot2bin.sv
// -----------------------------------------------------------------------------
// tb_dec_onehot2bin
// Directed plus randomized bench for dec_onehot2bin. A behavioural model of
// the decode rules and the handshake stage predicts every output.
// -----------------------------------------------------------------------------
module tb_dec_onehot2bin;

  logic        clk_s = 1'b0;
  logic        rst_s;
  logic        in_valid_s;
  logic        in_ready_s;
  logic [14:0] in_s;
  logic        out_valid_s;
  logic        out_ready_s;
  logic [3:0]  out_s;
  logic        out_err_s;
  logic [7:0]  err_cnt_s;
  logic        err_clr_s;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  bit m_valid;
  int m_out;
  bit m_err;
  int m_cnt;

  always #5 clk_s = ~clk_s;

  dec_onehot2bin dut (
    .clk       (clk_s),
    .rst       (rst_s),
    .in_valid  (in_valid_s),
    .in_ready  (in_ready_s),
    .in        (in_s),
    .out_valid (out_valid_s),
    .out_ready (out_ready_s),
    .out       (out_s),
    .out_err   (out_err_s),
    .err_cnt   (err_cnt_s),
    .err_clr   (err_clr_s)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference decode: lowest set bit from w & -w, popcount for the error flag.
  task automatic ref_decode(input logic [14:0] w, output int idx, output bit err);
    logic [14:0] low;
    int ones;
    ones = $countones(w);
    low  = w & (~w + 15'd1);
    if (ones == 0) begin
      idx = 15;
      err = 1'b0;
    end else begin
      idx = $clog2(low);
      err = (ones > 1);
    end
  endtask

  // One clock: check in_ready against the model, step model and DUT, check outputs.
  task automatic tick(input string tag);
    bit exp_ready;
    bit acc;
    int idx;
    bit err;
    #1;
    exp_ready = !m_valid || out_ready_s;
    chk({tag, ".in_ready"}, int'(in_ready_s), int'(exp_ready));
    acc = in_valid_s && exp_ready;
    ref_decode(in_s, idx, err);
    @(posedge clk_s);
    #1;
    if (!rst_s) begin
      m_valid = 1'b0; m_out = 0; m_err = 1'b0; m_cnt = 0;
    end else begin
      if (err_clr_s) m_cnt = (acc && err) ? 1 : 0;
      else if (acc && err && m_cnt < 255) m_cnt = m_cnt + 1;
      if (acc) begin
        m_valid = 1'b1; m_out = idx; m_err = err;
      end else if (out_ready_s) begin
        m_valid = 1'b0;
      end
    end
    chk({tag, ".out_valid"}, int'(out_valid_s), int'(m_valid));
    chk({tag, ".out"},       int'(out_s),       m_out);
    chk({tag, ".out_err"},   int'(out_err_s),   int'(m_err));
    chk({tag, ".err_cnt"},   int'(err_cnt_s),   m_cnt);
  endtask

  initial begin
    m_valid = 1'b0; m_out = 0; m_err = 1'b0; m_cnt = 0;
    rst_s = 1'b0; in_valid_s = 1'b0; in_s = 15'h0000;
    out_ready_s = 1'b1; err_clr_s = 1'b0;
    @(posedge clk_s); #1;

    // reset for two edges
    tick("reset0");
    tick("reset1");
    chk("reset.out_valid", int'(out_valid_s), 0);
    chk("reset.err_cnt",   int'(err_cnt_s),   0);

    // one-hot sweep on consecutive cycles
    rst_s = 1'b1;
    in_valid_s = 1'b1;
    for (int k = 0; k < 15; k++) begin
      in_s = 15'(1) << k;
      tick("sweep");
      chk("sweep.out_k", int'(out_s), k);
    end

    // zero word decodes to 15, no error
    in_s = 15'h0000;
    tick("zero");
    chk("zero.out15", int'(out_s), 15);

    // multi-hot words
    in_s = 15'h0028;
    tick("multi28");
    chk("multi28.out", int'(out_s), 3);
    chk("multi28.cnt", int'(err_cnt_s), 1);
    in_s = 15'h7FFF;
    tick("multi7fff");
    chk("multi7fff.out", int'(out_s), 0);
    chk("multi7fff.cnt", int'(err_cnt_s), 2);

    // backpressure: hold out=8 for 5 cycles while in changes
    in_s = 15'h0100;
    tick("bp_load");
    out_ready_s = 1'b0;
    in_s = 15'h0004;
    for (int i = 0; i < 5; i++) begin
      tick("bp_hold");
      chk("bp_hold.out8", int'(out_s), 8);
    end
    out_ready_s = 1'b1;
    tick("bp_release");
    chk("bp_release.out2", int'(out_s), 2);
    in_valid_s = 1'b0;
    tick("bp_drain");
    chk("bp_drain.valid0", int'(out_valid_s), 0);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      int sel;
      sel = int'($urandom_range(0, 3));
      if (sel == 0)      in_s = 15'(1) << $urandom_range(0, 14);
      else if (sel == 1) in_s = 15'h0000;
      else               in_s = 15'($urandom());
      in_valid_s  = ($urandom_range(0, 3) != 0);
      out_ready_s = ($urandom_range(0, 3) != 0);
      err_clr_s   = ($urandom_range(0, 15) == 0);
      tick("rand");
    end

    // counter saturation
    out_ready_s = 1'b1;
    in_valid_s  = 1'b0;
    err_clr_s   = 1'b1;
    tick("cnt_clr0");
    err_clr_s   = 1'b0;
    in_valid_s  = 1'b1;
    for (int i = 0; i < 260; i++) begin
      in_s = 15'h0003 << $urandom_range(0, 13);
      tick("cnt_inc");
    end
    chk("cnt.sat255", int'(err_cnt_s), 255);
    err_clr_s = 1'b1;
    in_s = 15'h0041;
    tick("cnt_clr_hit");
    chk("cnt.clr_hit1", int'(err_cnt_s), 1);
    in_valid_s = 1'b0;
    tick("cnt_clr_alone");
    chk("cnt.clr_alone0", int'(err_cnt_s), 0);
    err_clr_s = 1'b0;

    // reset with a word held under backpressure
    in_valid_s = 1'b1;
    in_s = 15'h0006;
    tick("rst_load");
    out_ready_s = 1'b0;
    in_valid_s  = 1'b0;
    tick("rst_hold");
    chk("rst_hold.valid1", int'(out_valid_s), 1);
    rst_s = 1'b0;
    tick("rst_mid");
    chk("rst_mid.valid0", int'(out_valid_s), 0);
    chk("rst_mid.out0",   int'(out_s),       0);
    chk("rst_mid.err0",   int'(out_err_s),   0);
    chk("rst_mid.cnt0",   int'(err_cnt_s),   0);
    rst_s = 1'b1;
    out_ready_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick("rst_after");
      chk("rst_after.no_delivery", int'(out_valid_s), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_dec_onehot2bin
